// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler framing 1..2^LEN_W byte SPI transactions for two requesters over one byte master.
// Optional WAIT timeout abort is built when SPI_SCHED_TIMEOUT_EN is defined.
module spi_xfer_sched #(
  parameter int LEN_W       = 4,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       gnt,
  input  logic [7:0]       tx_data0,
  input  logic [7:0]       tx_data1,
  input  logic [1:0]       tx_valid,
  output logic [1:0]       tx_ready,
  output logic [7:0]       rx_data,
  output logic [1:0]       rx_valid,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             busy,
  output logic             spi_start,
  output logic [7:0]       spi_data_in,
  input  logic             spi_done,
  input  logic [7:0]       spi_data_out,
  output logic             frame_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_FETCH, S_START, S_WAIT, S_RESP, S_GAP
  } state_t;

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic [LEN_W:0]   remaining, remaining_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             pick, arb, in_xfer_nxt, wait_expired;
  logic [LEN_W-1:0] pick_len;

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  // owner doubles as the round-robin pointer: the other requester wins a tie
  assign pick     = owner ? ~req[0] : req[1];
  assign pick_len = pick ? req_len1 : req_len0;
  // the last GAP cycle arbitrates directly so cs_n stays high exactly GAP_CYC cycles
  assign arb      = ((state == S_IDLE) || (state == S_GAP && gap_cnt == GAP_LAST)) && (|req);

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= '0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      err      <= (state == S_WAIT && !spi_done && wait_expired) ? oh(owner) : 2'b00;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign err          = 2'b00;
`endif

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    remaining_nxt = remaining;
    case (state)
      S_IDLE:  ;
      S_GRANT: state_nxt = S_FETCH;
      S_FETCH: if (tx_valid[owner]) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (spi_done)          state_nxt = S_RESP;
        else if (wait_expired) state_nxt = S_GAP;
      end
      S_RESP: begin
        remaining_nxt = remaining - (LEN_W+1)'(1);
        state_nxt     = (remaining == (LEN_W+1)'(1)) ? S_GAP : S_FETCH;
      end
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (arb) begin
      state_nxt     = S_GRANT;
      owner_nxt     = pick;
      remaining_nxt = {~|pick_len, pick_len};
    end
  end

  assign in_xfer_nxt = (state_nxt == S_GRANT) || (state_nxt == S_FETCH) || (state_nxt == S_START) ||
                       (state_nxt == S_WAIT)  || (state_nxt == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b1;
      remaining   <= '0;
      gap_cnt     <= '0;
      gnt         <= 2'b00;
      tx_ready    <= 2'b00;
      rx_valid    <= 2'b00;
      rx_data     <= 8'h00;
      done        <= 2'b00;
      busy        <= 1'b0;
      spi_start   <= 1'b0;
      spi_data_in <= 8'h00;
      frame_cs_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      remaining  <= remaining_nxt;
      gap_cnt    <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      gnt        <= in_xfer_nxt ? oh(owner_nxt) : 2'b00;
      frame_cs_n <= ~in_xfer_nxt;
      tx_ready   <= (state_nxt == S_FETCH) ? oh(owner_nxt) : 2'b00;
      spi_start  <= (state_nxt == S_START);
      rx_valid   <= (state_nxt == S_RESP) ? oh(owner) : 2'b00;
      done       <= (state_nxt == S_RESP && remaining == (LEN_W+1)'(1)) ? oh(owner) : 2'b00;
      busy       <= (state_nxt != S_IDLE);
      if (state == S_FETCH && tx_valid[owner])
        spi_data_in <= owner ? tx_data1 : tx_data0;
      if (state == S_WAIT && spi_done)
        rx_data <= spi_data_out;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched: table of transactions plus reset-in-WAIT and timeout sequences.
module tb_spi_xfer_sched;
  localparam int LEN_W       = 4;
  localparam int GAP_CYC     = 8;
  localparam int TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [LEN_W-1:0] req_len0, req_len1;
  logic [1:0]       gnt;
  logic [7:0]       tx_data0, tx_data1;
  logic [1:0]       tx_valid, tx_ready;
  logic [7:0]       rx_data;
  logic [1:0]       rx_valid, done, err;
  logic             busy, spi_start, spi_done, frame_cs_n;
  logic [7:0]       spi_data_in, spi_data_out;

  always #5 clk = ~clk;

  spi_xfer_sched #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .gnt(gnt), .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err),
    .busy(busy), .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_done(spi_done),
    .spi_data_out(spi_data_out), .frame_cs_n(frame_cs_n)
  );

  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   gap_run = 0;
  int   mst_cnt = 0;
  bit   master_en = 1'b1;
  logic force_done = 1'b0;
  logic mst_done = 1'b0;
  logic [7:0] mst_byte = 8'h00;

  assign spi_done = mst_done | force_done;

  function automatic logic [7:0] swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte master model: answers each spi_start with the nibble-swapped byte three cycles later
  initial begin
    spi_data_out = 8'h00;
    forever begin
      tick();
      mst_done = 1'b0;
      if (mst_cnt > 0) begin
        mst_cnt--;
        if (mst_cnt == 0) begin
          mst_done     = 1'b1;
          spi_data_out = swap(mst_byte);
        end
      end
      if (spi_start) begin
        start_cnt++;
        if (master_en) begin
          mst_byte = spi_data_in;
          mst_cnt  = 3;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]       r;
    logic [LEN_W-1:0] l0;
    logic [LEN_W-1:0] l1;
    logic [1:0]       exp_gnt;
    int               nbytes;
    logic [7:0]       b0;
    logic [7:0]       b1;
    bit               keep;
    bit               chk_gap;
    int               stall;
  } vec_t;

  task automatic do_xfer(input vec_t v);
    int         n;
    int         s0;
    int         s1;
    logic       own;
    logic       cs_bad;
    logic [7:0] b;
    req = v.r; req_len0 = v.l0; req_len1 = v.l1;
    n = 0;
    while (gnt == 2'b00 && n < 100) begin
      tick();
      if (gnt == 2'b00) gap_run++;
      n++;
    end
    chk("grant", 32'(gnt), 32'(v.exp_gnt));
    if (v.chk_gap) chk("gap_cycles", 32'(gap_run), 32'(GAP_CYC));
    if (!v.keep) req = 2'b00;
    own = v.exp_gnt[1];
    tx_valid[!own] = 1'b1;
    if (own) tx_data0 = 8'hEE; else tx_data1 = 8'hEE;
    s0 = start_cnt;
    cs_bad = 1'b0;
    for (int k = 0; k < v.nbytes; k++) begin
      n = 0;
      while (!tx_ready[own] && n < 100) begin
        tick();
        cs_bad |= frame_cs_n;
        n++;
      end
      chk("tx_ready_latency", 32'(n), 32'd1);
      chk("tx_ready_other", 32'(tx_ready[!own]), 32'd0);
      if (k == 1 && v.stall > 0) begin
        s1 = start_cnt;
        for (int i = 0; i < v.stall; i++) begin
          tick();
          cs_bad |= frame_cs_n;
        end
        chk("stall_no_start", 32'(start_cnt - s1), 32'd0);
        chk("stall_tx_ready", 32'(tx_ready), 32'(v.exp_gnt));
      end
      b = (k == 0) ? v.b0 : (k == 1) ? v.b1 : v.b0 + 8'(k);
      if (own) tx_data1 = b; else tx_data0 = b;
      tx_valid[own] = 1'b1;
      tick();
      cs_bad |= frame_cs_n;
      tx_valid[own] = 1'b0;
      chk("spi_start", 32'(spi_start), 32'd1);
      chk("spi_data_in", 32'(spi_data_in), 32'(b));
      n = 0;
      while (rx_valid == 2'b00 && n < 50) begin
        tick();
        cs_bad |= frame_cs_n;
        n++;
      end
      chk("rx_valid", 32'(rx_valid), 32'(v.exp_gnt));
      chk("rx_data", 32'(rx_data), 32'(swap(b)));
      chk("done", 32'(done), (k == v.nbytes - 1) ? 32'(v.exp_gnt) : 32'd0);
    end
    chk("start_count", 32'(start_cnt - s0), 32'(v.nbytes));
    chk("cs_low_in_frame", 32'(cs_bad), 32'd0);
    tick();
    chk("cs_after_done", 32'(frame_cs_n), 32'd1);
    chk("gnt_after_done", 32'(gnt), 32'd0);
    gap_run = 1;
    tx_valid = 2'b00;
  endtask

  vec_t tbl[8];
  vec_t post;

  initial begin
    int   n;
    logic seen;
    tbl[0] = '{2'b01, 4'd2, 4'd0, 2'b01, 2,  8'hA5, 8'h3C, 1'b0, 1'b0, 0};
    tbl[1] = '{2'b10, 4'd1, 4'd2, 2'b10, 2,  8'h11, 8'h22, 1'b0, 1'b1, 0};
    tbl[2] = '{2'b11, 4'd1, 4'd1, 2'b01, 1,  8'h61, 8'h00, 1'b1, 1'b1, 0};
    tbl[3] = '{2'b11, 4'd1, 4'd1, 2'b10, 1,  8'h72, 8'h00, 1'b1, 1'b1, 0};
    tbl[4] = '{2'b11, 4'd1, 4'd1, 2'b01, 1,  8'h83, 8'h00, 1'b1, 1'b1, 0};
    tbl[5] = '{2'b11, 4'd1, 4'd1, 2'b10, 1,  8'h94, 8'h00, 1'b1, 1'b1, 0};
    tbl[6] = '{2'b10, 4'd1, 4'd0, 2'b10, 16, 8'hB0, 8'hB1, 1'b0, 1'b1, 0};
    tbl[7] = '{2'b01, 4'd3, 4'd0, 2'b01, 3,  8'hC0, 8'hC1, 1'b0, 1'b1, 50};
    post   = '{2'b01, 4'd1, 4'd0, 2'b01, 1,  8'hD5, 8'h00, 1'b0, 1'b0, 0};

    rst_n = 1'b0; req = 2'b00; req_len0 = '0; req_len1 = '0;
    tx_data0 = 8'h00; tx_data1 = 8'h00; tx_valid = 2'b00;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_data_in", 32'(spi_data_in), 32'd0);
    chk("rst_cs_n", 32'(frame_cs_n), 32'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_xfer(tbl[i]);

    // reset pulse while the master is mid-byte; its late spi_done must be ignored
    req = 2'b01; req_len0 = 4'd3;
    n = 0;
    while (tx_ready[0] == 1'b0 && n < 100) begin tick(); n++; end
    req = 2'b00;
    tx_data0 = 8'h99; tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    chk("mid_spi_start", 32'(spi_start), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_outputs",
        32'({gnt, tx_ready, rx_valid, done, err, busy, spi_start, frame_cs_n}), 32'h001);
    chk("mid_rst_data", 32'({rx_data, spi_data_in}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= (rx_valid != 2'b00) || (done != 2'b00) || busy;
    end
    chk("stale_done_ignored", 32'(seen), 32'd0);
    gap_run = 0;
    do_xfer(post);

`ifdef SPI_SCHED_TIMEOUT_EN
    master_en = 1'b0;
    req = 2'b01; req_len0 = 4'd1;
    n = 0;
    while (tx_ready[0] == 1'b0 && n < 100) begin tick(); n++; end
    req = 2'b00;
    tx_data0 = 8'h77; tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    tick();
    n = 0; seen = 1'b0;
    while (err == 2'b00 && n < 40) begin
      tick();
      seen |= (rx_valid != 2'b00) || (done != 2'b00);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TIMEOUT_CYC));
    chk("timeout_err", 32'(err), 32'b01);
    chk("timeout_no_rx_done", 32'(seen), 32'd0);
    chk("timeout_release", 32'({gnt, frame_cs_n}), 32'b001);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= (rx_valid != 2'b00) || (done != 2'b00) || (err != 2'b00);
    end
    chk("late_done_ignored", 32'(seen), 32'd0);
    master_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

Transaction scheduler that shares one byte-level SPI master (8-bit `start`/`done` engine) between two requesters. It runs multi-byte transactions of 1–16 bytes on behalf of each requester and frames them with its own chip-select. It streams TX bytes in and RX bytes out, and arbitrates round-robin between requesters. It sits between the PIM instruction loader / host bridge and the SPI byte master in the PIM instruction path.

## Interface
Parameters:
- `LEN_W`, 4: width of the byte-count field; count 0 encodes 2^LEN_W bytes.
- `GAP_CYC`, 8: idle cycles with `frame_cs_n` high between transactions (≥1).
- `TIMEOUT_CYC`, 4096: maximum cycles spent waiting for `spi_done`. Used only with the timeout feature.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `req` in 2: per-requester transaction request (level).
- `req_len0`, `req_len1` in LEN_W: byte count, latched at grant.
- `gnt` out 2: one-hot owner indication, high for the whole transaction.
- `tx_data0`, `tx_data1` in 8: next TX byte.
- `tx_valid` in 2 / `tx_ready` out 2: per-requester TX handshake.
- `rx_data` out 8: received byte, shared between requesters.
- `rx_valid` out 2: one-cycle RX strobe to the owner; no backpressure.
- `done` out 2: one-cycle pulse when the owner's transaction ends.
- `err` out 2: one-cycle pulse on timeout abort.
- `busy` out 1: high whenever the FSM is not IDLE.
- `spi_start` out 1, `spi_data_in` out 8: to the byte master.
- `spi_done` in 1, `spi_data_out` in 8: from the byte master.
- `frame_cs_n` out 1: transaction-level chip select, active low.

## Operation
- States: IDLE, GRANT, FETCH, START, WAIT, RESP, GAP.
- IDLE: if any `req` bit is high, pick a requester round-robin, starting after the last one granted. The pointer resets so that requester 0 wins the first tie.
- IDLE → GRANT: set `gnt` one-hot, latch the length into `remaining`, drive `frame_cs_n` low.
- GRANT → FETCH.
- FETCH: the owner's `tx_ready` is high. When `tx_valid` and `tx_ready` are both high, capture the byte and go to START. FETCH waits indefinitely; `frame_cs_n` stays low while it waits.
- START: `spi_start`=1 for exactly one cycle, with `spi_data_in` = captured byte. → WAIT.
- WAIT: when `spi_done`=1, capture `spi_data_out` into `rx_data` and go to RESP.
- RESP: `rx_valid[owner]`=1 for one cycle; decrement `remaining`.
  - If `remaining` was 1: pulse `done[owner]`, drop `gnt`, drive `frame_cs_n` high, go to GAP.
  - Otherwise go to FETCH.
- GAP: count `GAP_CYC` cycles, then go to IDLE.
- `spi_done` is ignored in every state except WAIT.
- `tx_valid` from the non-owner is ignored; its `tx_ready` stays 0.
- Dropping `req` mid-transaction has no effect; the transaction runs to its latched length.
- `req` still high in GAP is serviced only after GAP ends. The other requester takes priority if it is also requesting.
- `remaining` is LEN_W+1 bits wide; a latched length of 0 loads 2^LEN_W.
- `rx_data` holds its last value until the next capture.

## Timing
- Reset values: `gnt`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `done`=0, `err`=0, `busy`=0, `spi_start`=0, `spi_data_in`=0, `frame_cs_n`=1. The FSM is in IDLE and the round-robin pointer points at requester 1, so requester 0 is next.
- `req` seen at cycle T: `gnt` and `frame_cs_n` low at T+1; `tx_ready` at T+2.
- TX handshake at cycle H: `spi_start` at H+1; WAIT begins at H+2.
- `spi_done` at cycle D: `rx_valid` and new `rx_data` at D+1. For a non-final byte, `tx_ready` returns at D+2.
- Final byte: `done` pulses together with `rx_valid`. `frame_cs_n` goes high the next cycle. The next `gnt` comes no earlier than `GAP_CYC`+1 cycles after `done`.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge and no `done` is pulsed. A stale `spi_done` that arrives afterwards is ignored.
- All outputs are registered.

## Configuration
- `SPI_SCHED_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs. If it reaches `TIMEOUT_CYC` without `spi_done`, pulse `err[owner]`, drop `gnt`, drive `frame_cs_n` high and go to GAP.
  - No `rx_valid` and no `done` are produced for an aborted transaction.
  - The counter clears on entry to WAIT.
- Not defined: no counter is built, WAIT waits forever, and `err` is tied to 0.

## Test plan
- Reset, then `req`=01 with `req_len0`=2 and TX bytes A5, 3C; master model returns 5A, C3.
  - Requires `spi_start` twice with `spi_data_in` = A5 then 3C.
  - Requires `rx_valid[0]` with `rx_data` = 5A then C3, `done[0]` on the second `rx_valid`, and `frame_cs_n` low throughout the transaction.
- `req`=11 held continuously, lengths 1 each: grants alternate 0,1,0,1. `frame_cs_n` is high for exactly `GAP_CYC` cycles between frames.
- `req_len1`=0: exactly 16 `spi_start` pulses are issued before `done[1]`.
- `tx_valid` held low for 50 cycles mid-transaction: `frame_cs_n` stays low, no `spi_start` is issued, and the transaction resumes on `tx_valid`.
- With `SPI_SCHED_TIMEOUT_EN` and `TIMEOUT_CYC`=16, the master never asserts `spi_done`:
  - Requires `err[0]` pulsed 16 cycles after WAIT entry, with no `done` and no `rx_valid`.
  - A late `spi_done` is ignored.
- `rst_n` low for 1 cycle during WAIT: all outputs are at reset values the next cycle, and a subsequent request works normally.
